// File: rtl/cache_bus_arbiter.sv
// Shares the memory-bus read channel between ICache and DCache refills with
// round-robin arbitration, and sequences the single outstanding DCache write.
module cache_bus_arbiter #(
  parameter int LINE_BEATS  = 4,
  parameter int LINE_OFFSET = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // ICache read port
  input  logic                    i_rd_req,
  input  logic [2:0]              i_rd_type,
  input  logic [31:0]             i_rd_addr,
  output logic                    i_rd_rdy,
  output logic                    i_ret_valid,
  output logic                    i_ret_last,
  // DCache read port
  input  logic                    d_rd_req,
  input  logic [2:0]              d_rd_type,
  input  logic [31:0]             d_rd_addr,
  output logic                    d_rd_rdy,
  output logic                    d_ret_valid,
  output logic                    d_ret_last,
  output logic [31:0]             ret_data,
  // DCache write port
  input  logic                    d_wr_req,
  input  logic [2:0]              d_wr_type,
  input  logic [31:0]             d_wr_addr,
  input  logic [3:0]              d_wr_wstrb,
  input  logic [32*LINE_BEATS-1:0] d_wr_data,
  output logic                    d_wr_rdy,
  output logic                    d_wr_done,
  // Bus read channel
  output logic                    bus_rd_req,
  output logic [2:0]              bus_rd_type,
  output logic [31:0]             bus_rd_addr,
  input  logic                    bus_rd_rdy,
  input  logic                    bus_ret_valid,
  input  logic                    bus_ret_last,
  input  logic [31:0]             bus_ret_data,
  // Bus write channel
  output logic                    bus_wr_req,
  output logic [2:0]              bus_wr_type,
  output logic [31:0]             bus_wr_addr,
  output logic [3:0]              bus_wr_wstrb,
  output logic [32*LINE_BEATS-1:0] bus_wr_data,
  input  logic                    bus_wr_rdy,
  input  logic                    bus_wr_done,
  output logic                    proto_err
);

  localparam int         CNT_W     = $clog2(LINE_BEATS) + 1;
  localparam logic [2:0] TYPE_LINE = 3'd4;

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wr_state_e;
  typedef enum logic       {OWN_I, OWN_D}          owner_e;

  rd_state_e                rd_state_q, rd_state_d;
  wr_state_e                wr_state_q, wr_state_d;
  owner_e                   owner_q, owner_d;
  owner_e                   last_owner_q, last_owner_d;
  logic [2:0]               rd_type_q, rd_type_d;
  logic [31:0]              rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic [2:0]               wr_type_q, wr_type_d;
  logic [31:0]              wr_addr_q, wr_addr_d;
  logic [3:0]               wr_wstrb_q, wr_wstrb_d;
  logic [32*LINE_BEATS-1:0] wr_data_q, wr_data_d;
  logic                     proto_err_q, proto_err_d;

  logic             d_rd_blocked, d_elig;
  logic             rd_err, wr_err;
  logic [CNT_W-1:0] final_beat;
  logic             is_final;

  // A D read may not overtake a write-back to its own line, including one
  // being accepted in this very cycle.
  always_comb begin
    d_rd_blocked = 1'b0;
    if (wr_state_q != W_IDLE)
      d_rd_blocked = (d_rd_addr[31:LINE_OFFSET] == wr_addr_q[31:LINE_OFFSET]);
    else if (d_wr_req)
      d_rd_blocked = (d_rd_addr[31:LINE_OFFSET] == d_wr_addr[31:LINE_OFFSET]);
  end

  assign d_elig     = d_rd_req && !d_rd_blocked;
  assign final_beat = (rd_type_q == TYPE_LINE) ? CNT_W'(LINE_BEATS - 1) : '0;
  assign is_final   = (beat_cnt_q >= final_beat);
  assign ret_data   = bus_ret_data;

  // NOTE: every output and next-state value gets a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_state_d   = rd_state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rd_type_d    = rd_type_q;
    rd_addr_d    = rd_addr_q;
    beat_cnt_d   = beat_cnt_q;
    i_rd_rdy     = 1'b0;
    d_rd_rdy     = 1'b0;
    i_ret_valid  = 1'b0;
    i_ret_last   = 1'b0;
    d_ret_valid  = 1'b0;
    d_ret_last   = 1'b0;
    bus_rd_req   = 1'b0;
    rd_err       = 1'b0;

    unique case (rd_state_q)
      R_IDLE: begin
        rd_err     = bus_ret_valid;
        beat_cnt_d = '0;
        if (i_rd_req && (!d_elig || last_owner_q == OWN_D)) begin
          i_rd_rdy   = 1'b1;
          owner_d    = OWN_I;
          rd_type_d  = i_rd_type;
          rd_addr_d  = i_rd_addr;
          rd_state_d = R_REQ;
        end else if (d_elig) begin
          d_rd_rdy   = 1'b1;
          owner_d    = OWN_D;
          rd_type_d  = d_rd_type;
          rd_addr_d  = d_rd_addr;
          rd_state_d = R_REQ;
        end
      end
      R_REQ: begin
        bus_rd_req = 1'b1;
        rd_err     = bus_ret_valid;
        beat_cnt_d = '0;
        if (bus_rd_rdy) rd_state_d = R_WAIT;
      end
      R_WAIT: begin
        if (bus_ret_valid) begin
          // A beat whose last flag disagrees with the expected count is dropped.
          if (bus_ret_last != is_final) begin
            rd_err = 1'b1;
          end else if (owner_q == OWN_I) begin
            i_ret_valid = 1'b1;
            i_ret_last  = bus_ret_last;
          end else begin
            d_ret_valid = 1'b1;
            d_ret_last  = bus_ret_last;
          end
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (bus_ret_last) begin
            last_owner_d = owner_q;
            rd_state_d   = R_IDLE;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_type_d  = wr_type_q;
    wr_addr_d  = wr_addr_q;
    wr_wstrb_d = wr_wstrb_q;
    wr_data_d  = wr_data_q;
    d_wr_rdy   = 1'b0;
    d_wr_done  = 1'b0;
    bus_wr_req = 1'b0;

    unique case (wr_state_q)
      W_IDLE: begin
        if (d_wr_req) begin
          d_wr_rdy   = 1'b1;
          wr_type_d  = d_wr_type;
          wr_addr_d  = d_wr_addr;
          wr_wstrb_d = d_wr_wstrb;
          wr_data_d  = d_wr_data;
          wr_state_d = W_REQ;
        end
      end
      W_REQ: begin
        bus_wr_req = 1'b1;
        if (bus_wr_rdy) wr_state_d = W_WAIT;
      end
      W_WAIT: begin
        if (bus_wr_done) begin
          d_wr_done  = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign wr_err      = bus_wr_done && (wr_state_q != W_WAIT);
  assign proto_err_d = proto_err_q || rd_err || wr_err;

  assign bus_rd_type  = rd_type_q;
  assign bus_rd_addr  = rd_addr_q;
  assign bus_wr_type  = wr_type_q;
  assign bus_wr_addr  = wr_addr_q;
  assign bus_wr_wstrb = wr_wstrb_q;
  assign bus_wr_data  = wr_data_q;
  assign proto_err    = proto_err_q;

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order. The payload registers are
  // reset too so the bus never sees stale or X data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q   <= R_IDLE;
      wr_state_q   <= W_IDLE;
      owner_q      <= OWN_D;
      last_owner_q <= OWN_D;
      rd_type_q    <= '0;
      rd_addr_q    <= '0;
      beat_cnt_q   <= '0;
      wr_type_q    <= '0;
      wr_addr_q    <= '0;
      wr_wstrb_q   <= '0;
      wr_data_q    <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      rd_state_q   <= rd_state_d;
      wr_state_q   <= wr_state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rd_type_q    <= rd_type_d;
      rd_addr_q    <= rd_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_type_q    <= wr_type_d;
      wr_addr_q    <= wr_addr_d;
      wr_wstrb_q   <= wr_wstrb_d;
      wr_data_q    <= wr_data_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed scenarios plus randomized
// read traffic checked against a round-robin transaction model.
module tb_cache_bus_arbiter;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic i_rd_req, d_rd_req, d_wr_req;
  logic [2:0] i_rd_type, d_rd_type, d_wr_type;
  logic [31:0] i_rd_addr, d_rd_addr, d_wr_addr;
  logic [3:0] d_wr_wstrb;
  logic [32*LB-1:0] d_wr_data;
  logic i_rd_rdy, i_ret_valid, i_ret_last;
  logic d_rd_rdy, d_ret_valid, d_ret_last;
  logic [31:0] ret_data;
  logic d_wr_rdy, d_wr_done;
  logic bus_rd_req, bus_rd_rdy, bus_ret_valid, bus_ret_last;
  logic [2:0] bus_rd_type, bus_wr_type;
  logic [31:0] bus_rd_addr, bus_ret_data, bus_wr_addr;
  logic bus_wr_req, bus_wr_rdy, bus_wr_done;
  logic [3:0] bus_wr_wstrb;
  logic [32*LB-1:0] bus_wr_data;
  logic proto_err;

  int n_cmp = 0;
  int n_mis = 0;

  cache_bus_arbiter #(.LINE_BEATS(LB), .LINE_OFFSET(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
    .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
    .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
    .ret_data(ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data),
    .d_wr_rdy(d_wr_rdy), .d_wr_done(d_wr_done),
    .bus_rd_req(bus_rd_req), .bus_rd_type(bus_rd_type), .bus_rd_addr(bus_rd_addr),
    .bus_rd_rdy(bus_rd_rdy), .bus_ret_valid(bus_ret_valid),
    .bus_ret_last(bus_ret_last), .bus_ret_data(bus_ret_data),
    .bus_wr_req(bus_wr_req), .bus_wr_type(bus_wr_type), .bus_wr_addr(bus_wr_addr),
    .bus_wr_wstrb(bus_wr_wstrb), .bus_wr_data(bus_wr_data),
    .bus_wr_rdy(bus_wr_rdy), .bus_wr_done(bus_wr_done),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
    d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
    d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = '0;
    bus_rd_rdy = 0; bus_ret_valid = 0; bus_ret_last = 0; bus_ret_data = 0;
    bus_wr_rdy = 0; bus_wr_done = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 0;
    #1;
    check("rst_ctrl", {i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid,
                       d_ret_last, d_wr_rdy, d_wr_done, bus_rd_req, bus_wr_req, proto_err}, 0);
    check("rst_payload", {bus_rd_type, bus_rd_addr, bus_wr_type, bus_wr_addr, bus_wr_wstrb}, 0);
    check("rst_wdata", 64'(bus_wr_data == '0), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    tick();
  endtask

  // Plays the bus side of one read whose grant happened on the previous edge,
  // and checks the beats reach only the expected owner (0 = I, 1 = D).
  task automatic serve_read(input bit own, input logic [2:0] typ, input logic [31:0] addr,
                            input logic [31:0] base, input int max_stall, input int max_gap);
    int nb, ns, ng;
    nb = (typ == 3'd4) ? LB : 1;
    check("bus_rd_req", bus_rd_req, 1);
    check("bus_rd_type", bus_rd_type, typ);
    check("bus_rd_addr", bus_rd_addr, addr);
    ns = int'($urandom_range(max_stall, 0));
    for (int k = 0; k < ns; k++) begin
      bus_rd_rdy = 0;
      tick();
      check("bus_rd_hold", {bus_rd_req, bus_rd_addr}, {1'b1, addr});
    end
    bus_rd_rdy = 1;
    tick();
    bus_rd_rdy = 0;
    check("bus_rd_drop", bus_rd_req, 0);
    for (int b = 0; b < nb; b++) begin
      ng = int'($urandom_range(max_gap, 0));
      for (int g = 0; g < ng; g++) begin
        bus_ret_valid = 0;
        #1;
        check("ret_gap", {i_ret_valid, d_ret_valid}, 0);
        tick();
      end
      bus_ret_valid = 1;
      bus_ret_last  = (b == nb - 1);
      bus_ret_data  = base + b;
      #1;
      check("ret_valid", {i_ret_valid, d_ret_valid}, own ? 2'b01 : 2'b10);
      check("ret_last", {i_ret_last, d_ret_last},
            (b == nb - 1) ? (own ? 2'b01 : 2'b10) : 2'b00);
      check("ret_data", ret_data, base + b);
      check("no_grant_busy", {i_rd_rdy, d_rd_rdy}, 0);
      tick();
    end
    bus_ret_valid = 0;
    bus_ret_last  = 0;
  endtask

  logic [2:0] type_tbl [4] = '{3'd0, 3'd1, 3'd2, 3'd4};

  initial begin
    logic [32*LB-1:0] wdata;
    bit last_own;
    bit i_pend, d_pend, win;

    // Single I line refill
    do_reset();
    i_rd_req = 1; i_rd_type = 3'd4; i_rd_addr = 32'h1C00_0000;
    #1;
    check("t1_i_rdy", i_rd_rdy, 1);
    check("t1_busreq_c0", bus_rd_req, 0);
    tick();
    i_rd_req = 0;
    serve_read(0, 3'd4, 32'h1C00_0000, 32'hA0, 0, 0);
    check("t1_proto", proto_err, 0);

    // Simultaneous I/D from reset, then round-robin
    do_reset();
    i_rd_req = 1; i_rd_type = 3'd4; i_rd_addr = 32'h0000_4000;
    d_rd_req = 1; d_rd_type = 3'd4; d_rd_addr = 32'h0000_8000;
    #1;
    check("t2_tie1", {i_rd_rdy, d_rd_rdy}, 2'b10);
    tick();
    i_rd_req = 0;
    serve_read(0, 3'd4, 32'h0000_4000, 32'h100, 1, 1);
    #1;
    check("t2_d_after_last", d_rd_rdy, 1);
    tick();
    d_rd_req = 0;
    serve_read(1, 3'd4, 32'h0000_8000, 32'h200, 1, 1);
    i_rd_req = 1; i_rd_type = 3'd2; i_rd_addr = 32'h0000_4100;
    #1;
    check("t2_i_alone", i_rd_rdy, 1);
    tick();
    i_rd_req = 0;
    serve_read(0, 3'd2, 32'h0000_4100, 32'h300, 0, 0);
    i_rd_req = 1; i_rd_type = 3'd4; i_rd_addr = 32'h0000_5000;
    d_rd_req = 1; d_rd_type = 3'd4; d_rd_addr = 32'h0000_9000;
    #1;
    check("t2_tie2", {i_rd_rdy, d_rd_rdy}, 2'b01);
    tick();
    d_rd_req = 0;
    serve_read(1, 3'd4, 32'h0000_9000, 32'h400, 0, 0);
    #1;
    check("t2_i_second", i_rd_rdy, 1);
    tick();
    i_rd_req = 0;
    serve_read(0, 3'd4, 32'h0000_5000, 32'h500, 0, 0);

    // Write sequencing and read-after-write hazard
    wdata = {$urandom, $urandom, $urandom, $urandom};
    d_wr_req = 1; d_wr_type = 3'd4; d_wr_addr = 32'h0000_1000;
    d_wr_wstrb = 4'hF; d_wr_data = wdata;
    d_rd_req = 1; d_rd_type = 3'd2; d_rd_addr = 32'h0000_1008;
    #1;
    check("t3_wr_rdy", d_wr_rdy, 1);
    check("t3_same_cycle_block", d_rd_rdy, 0);
    tick();
    d_wr_req = 0;
    for (int k = 0; k < 3; k++) begin
      bus_wr_rdy = 0;
      #1;
      check("t3_wr_held", {bus_wr_req, bus_wr_addr, bus_wr_type, bus_wr_wstrb},
            {1'b1, 32'h0000_1000, 3'd4, 4'hF});
      check("t3_wr_data", 64'(bus_wr_data == wdata), 1);
      check("t3_blocked_req", d_rd_rdy, 0);
      tick();
    end
    bus_wr_rdy = 1;
    tick();
    bus_wr_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_wait", {bus_wr_req, d_wr_done, d_rd_rdy}, 0);
      tick();
    end
    bus_wr_done = 1;
    #1;
    check("t3_done", d_wr_done, 1);
    check("t3_blocked_done", d_rd_rdy, 0);
    tick();
    bus_wr_done = 0;
    #1;
    check("t3_done_once", d_wr_done, 0);
    check("t3_unblocked", d_rd_rdy, 1);
    tick();
    d_rd_req = 0;
    serve_read(1, 3'd2, 32'h0000_1008, 32'hCAFE_0000, 1, 1);
    d_wr_req = 1; d_wr_addr = 32'h0000_1000;
    #1;
    check("t3_wr_rdy2", d_wr_rdy, 1);
    tick();
    d_wr_req = 0;
    d_rd_req = 1; d_rd_type = 3'd2; d_rd_addr = 32'h0000_2000;
    #1;
    check("t3_other_line", d_rd_rdy, 1);
    tick();
    d_rd_req = 0;
    serve_read(1, 3'd2, 32'h0000_2000, 32'hBEEF_0000, 0, 0);
    bus_wr_rdy = 1;
    tick();
    bus_wr_rdy = 0;
    bus_wr_done = 1;
    #1;
    check("t3_done2", d_wr_done, 1);
    tick();
    bus_wr_done = 0;
    check("t3_proto", proto_err, 0);

    // Uncached word read with last withheld
    d_rd_req = 1; d_rd_type = 3'd2; d_rd_addr = 32'h0000_3000;
    #1;
    check("t4_rdy", d_rd_rdy, 1);
    tick();
    d_rd_req = 0;
    check("t4_busreq", bus_rd_req, 1);
    bus_rd_rdy = 1;
    tick();
    bus_rd_rdy = 0;
    bus_ret_valid = 1; bus_ret_last = 0; bus_ret_data = 32'h1234_5678;
    #1;
    check("t4_not_fwd", {d_ret_valid, i_ret_valid}, 0);
    tick();
    bus_ret_valid = 0;
    #1;
    check("t4_proto", proto_err, 1);
    bus_ret_valid = 1; bus_ret_last = 1;
    tick();
    bus_ret_valid = 0; bus_ret_last = 0;

    // Reset in the middle of a line refill, then a stray beat
    do_reset();
    i_rd_req = 1; i_rd_type = 3'd4; i_rd_addr = 32'h0000_7000;
    tick();
    i_rd_req = 0;
    bus_rd_rdy = 1;
    tick();
    bus_rd_rdy = 0;
    for (int b = 0; b < 2; b++) begin
      bus_ret_valid = 1; bus_ret_data = 32'hD0 + b;
      #1;
      check("t5_beat", i_ret_valid, 1);
      tick();
    end
    rst_n = 0;
    #1;
    check("t5_abort", {i_ret_valid, i_ret_last, d_ret_valid, bus_rd_req, i_rd_rdy, proto_err}, 0);
    tick();
    rst_n = 1;
    #1;
    check("t5_stray_not_fwd", {i_ret_valid, d_ret_valid}, 0);
    tick();
    bus_ret_valid = 0;
    #1;
    check("t5_stray_proto", proto_err, 1);

    // Write completion outside the wait state
    do_reset();
    bus_wr_done = 1;
    #1;
    check("t6_done_blocked", d_wr_done, 0);
    tick();
    bus_wr_done = 0;
    check("t6_proto", proto_err, 1);

    // Randomized read traffic against a round-robin model
    do_reset();
    last_own = 1;
    i_pend = 0;
    d_pend = 0;
    for (int r = 0; r < 40; r++) begin
      if (!i_pend && $urandom_range(1, 0) == 1) begin
        i_pend = 1; i_rd_type = type_tbl[$urandom_range(3, 0)]; i_rd_addr = $urandom;
      end
      if (!d_pend && $urandom_range(1, 0) == 1) begin
        d_pend = 1; d_rd_type = type_tbl[$urandom_range(3, 0)]; d_rd_addr = $urandom;
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1; i_rd_type = type_tbl[$urandom_range(3, 0)]; i_rd_addr = $urandom;
      end
      i_rd_req = i_pend;
      d_rd_req = d_pend;
      win = (i_pend && d_pend) ? !last_own : d_pend;
      #1;
      check("rnd_grant", {i_rd_rdy, d_rd_rdy}, win ? 2'b01 : 2'b10);
      tick();
      if (win) begin
        d_pend = 0; d_rd_req = 0;
        serve_read(1, d_rd_type, d_rd_addr, $urandom, 3, 2);
      end else begin
        i_pend = 0; i_rd_req = 0;
        serve_read(0, i_rd_type, i_rd_addr, $urandom, 3, 2);
      end
      last_own = win;
    end
    i_rd_req = 0;
    d_rd_req = 0;
    check("rnd_proto", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Shares the core's single memory-bus read channel between the ICache refill port and the DCache refill/uncached-load port. It also sequences the DCache write-back/uncached-store channel. Sits between the two caches and the AXI bridge. Round-robin arbitration is applied on reads, and a same-line read-after-write hazard check prevents a DCache read from overtaking its own pending write-back.

## Interface
Parameters:
- `LINE_BEATS`, default 4: 32-bit beats per cache-line burst.
- `LINE_OFFSET`, default 4: byte-offset bits of a cache line, used for hazard compare.

Ports:
- `clk`, in, 1: core clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `i_rd_req` / `i_rd_type` / `i_rd_addr`, in, 1 / 3 / 32: ICache read request. `rd_type` encoding is shared with the DCache side: 0 = byte, 1 = half, 2 = word, 4 = line.
- `i_rd_rdy`, out, 1: ICache request accepted this cycle.
- `i_ret_valid` / `i_ret_last`, out, 1 / 1: ICache return beat and last-beat marker.
- `d_rd_req` / `d_rd_type` / `d_rd_addr`, in, 1 / 3 / 32: DCache read request.
- `d_rd_rdy`, `d_ret_valid`, `d_ret_last`, out, 1 each: same meaning as the ICache counterparts.
- `ret_data`, out, 32: return data, fanned out to both requesters (`bus_ret_data` pass-through).
- `d_wr_req` / `d_wr_type` / `d_wr_addr` / `d_wr_wstrb` / `d_wr_data`, in, 1 / 3 / 32 / 4 / 32*LINE_BEATS: DCache write request.
- `d_wr_rdy`, out, 1: write accepted. `d_wr_done`, out, 1: write completed.
- `bus_rd_req` / `bus_rd_type` / `bus_rd_addr`, out, 1 / 3 / 32: bus read request. `bus_rd_rdy`, in, 1: bus accepted the read.
- `bus_ret_valid`, `bus_ret_last`, in, 1 each; `bus_ret_data`, in, 32: bus return channel.
- `bus_wr_req` / `bus_wr_type` / `bus_wr_addr` / `bus_wr_wstrb` / `bus_wr_data`, out, 1 / 3 / 32 / 4 / 32*LINE_BEATS: bus write request. `bus_wr_rdy`, `bus_wr_done`, in, 1 each.
- `proto_err`, out, 1: sticky bus-protocol violation flag.

## Operation
Read FSM: states `R_IDLE`, `R_REQ`, `R_WAIT`.
- `R_IDLE`:
  - Eligible requests: `i_rd_req`, and `d_rd_req` only when it is not blocked by the hazard check.
  - If both are eligible, the requester other than `last_owner` wins. `last_owner` resets to D, so I wins the first tie.
  - The winner's `*_rd_rdy` is asserted combinationally in this cycle. Type and address are registered and `owner` is latched; go to `R_REQ`.
- `R_REQ`: `bus_rd_req`=1 with the registered type and address. On `bus_rd_rdy`, go to `R_WAIT`. The beat counter is cleared.
- `R_WAIT`:
  - `bus_ret_valid` is routed to `owner`'s `*_ret_valid`; `*_ret_last` = `bus_ret_last`. The beat counter increments per beat.
  - Expected beats = `LINE_BEATS` if type is 4, else 1.
  - On `bus_ret_last`: `last_owner` is set to `owner`; go to `R_IDLE`.
- Hazard check:
  - A D read is blocked while a write is in flight (write state not `W_IDLE`) and `d_rd_addr[31:LINE_OFFSET]` equals the registered write line address.
  - A D read is also blocked in a cycle where `d_wr_req` is accepted for the same line. The write wins.
  - I reads are never blocked.
- Write FSM: states `W_IDLE`, `W_REQ`, `W_WAIT`.
  - `W_IDLE`: `d_wr_req` gives `d_wr_rdy`=1 in the same cycle, the request is captured, and the FSM goes to `W_REQ`.
  - `W_REQ`: `bus_wr_req`=1 until `bus_wr_rdy`, then go to `W_WAIT`.
  - `W_WAIT`: `bus_wr_done` gives `d_wr_done`=1 (combinational pass, one cycle), then go to `W_IDLE`.
  - At most one write is outstanding. Reads and writes proceed independently apart from the hazard check.
- `proto_err` is set, and held until reset, on any of:
  - `bus_ret_valid` outside `R_WAIT`.
  - `bus_ret_last` on a beat other than the expected final beat.
  - The expected final beat arriving without `bus_ret_last`.
  - `bus_wr_done` outside `W_WAIT`.
  
  Offending beats are not forwarded.

## Timing
- Reset values: both FSMs in IDLE; `last_owner`=D; all `*_rdy`, `*_valid`, `*_last`, `*_req`, `d_wr_done`, and `proto_err` = 0; registered address, type, data, and strobe = 0.
- Reset asserted mid-transaction aborts immediately. Any in-flight bus beats arriving after reset release are flagged by `proto_err`.
- Read latency: request in cycle 0 (IDLE) gives `rdy` in cycle 0 and `bus_rd_req` in cycle 1. Return beats pass through combinationally with zero added latency.
- Back-to-back reads: the next grant occurs in the cycle after the last beat (one IDLE cycle).
- Requesters hold `req`, addr, type, and data stable until `rdy` is sampled high. The arbiter holds `bus_*_req` and its payload stable until `bus_*_rdy`.
- `bus_ret_last` with `bus_ret_valid` in the same cycle is the final beat.

## Test plan
- Single I line refill: `i_rd_req` with addr 0x1C00_0000 and type 4 gives `i_rd_rdy` in cycle 0 and `bus_rd_req` in cycle 1. After `bus_rd_rdy`, 4 beats 0xA0..0xA3 with last on the 4th appear on `i_ret_valid` and `ret_data`. `d_ret_valid` stays 0 and `proto_err`=0.
- Simultaneous I and D reads from reset: I granted first, then D one cycle after I's last beat. A second simultaneous pair grants D first, confirming round-robin.
- Read-after-write hazard: write to line 0x0000_1000 pending in `W_WAIT`; `d_rd_req` to 0x0000_1008 gives no `d_rd_rdy` until the cycle after `d_wr_done`. `d_rd_req` to 0x0000_2000 is granted immediately.
- Uncached word read (type 2): a single beat with last gives one `d_ret_valid` and `d_ret_last`. The same request with last withheld on beat 1 sets `proto_err`.
- Write sequencing: `d_wr_req` with `wstrb` 0xF gives `d_wr_rdy` in the same cycle. `bus_wr_req` is held across 3 stalled cycles of `bus_wr_rdy`=0, and `d_wr_done` pulses exactly once in the `bus_wr_done` cycle.
- Reset during `R_WAIT` after 2 of 4 beats: outputs go to 0 immediately and the FSM returns to IDLE. A stray `bus_ret_valid` after `rst_n` rises sets `proto_err` and is not forwarded.
